// File: rtl/pzcorebus_membus2csrbus_pkg.sv
// Shared types for the membus-to-csrbus adapter: command/state encodings and split context.
package pzcorebus_membus2csrbus_pkg;

    localparam int PKG_ADDR_WIDTH     = 32;
    localparam int PKG_MEM_DATA_WIDTH = 64;
    localparam int PKG_CSR_DATA_WIDTH = 32;
    localparam int PKG_LENGTH_WIDTH   = 8;
    localparam int PKG_ID_WIDTH       = 8;
    localparam int PKG_RATIO          = PKG_MEM_DATA_WIDTH / PKG_CSR_DATA_WIDTH;
    localparam int PKG_LANE_WIDTH     = (PKG_RATIO > 1) ? $clog2(PKG_RATIO) : 1;

    typedef enum logic [1:0] {
        CMD_READ             = 2'd0,
        CMD_WRITE            = 2'd1,
        CMD_WRITE_NON_POSTED = 2'd2,
        CMD_RESERVED         = 2'd3
    } cmd_type_e;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        READ_SPLIT  = 2'd1,
        WRITE_SPLIT = 2'd2
    } split_state_e;

    // One extra bit so a zero length can hold the full 2**LENGTH word count.
    typedef logic [PKG_LENGTH_WIDTH:0] remaining_t;
    typedef logic [PKG_LANE_WIDTH-1:0] lane_t;

    typedef struct packed {
        cmd_type_e                 cmd;
        logic [PKG_ID_WIDTH-1:0]   id;
        logic [PKG_ADDR_WIDTH-1:0] addr;
        remaining_t                remaining;
        lane_t                     lane;
    } split_ctx_t;

    function automatic remaining_t burst_words(input logic [PKG_LENGTH_WIDTH-1:0] length);
        return (length == '0) ? {1'b1, length} : {1'b0, length};
    endfunction

endpackage

// File: rtl/pzcorebus_membus2csrbus_adapter_lane_select.sv
// Purpose: picks one csr-width word and its byte enables out of a wide membus beat.
// Latency: combinational, zero cycles.
// Backpressure: none; pure datapath, the caller owns the handshake.
module pzcorebus_membus2csrbus_adapter_lane_select #(
    parameter int MEM_DATA_WIDTH = 64,
    parameter int CSR_DATA_WIDTH = 32,
    parameter int LANE_WIDTH     = 1
) (
    input  logic [LANE_WIDTH-1:0]       lane,
    input  logic [MEM_DATA_WIDTH-1:0]   mem_dat,
    input  logic [MEM_DATA_WIDTH/8-1:0] mem_byteen,
    output logic [CSR_DATA_WIDTH-1:0]   csr_dat,
    output logic [CSR_DATA_WIDTH/8-1:0] csr_byteen
);
    localparam int R = MEM_DATA_WIDTH / CSR_DATA_WIDTH;

    always_comb begin
        csr_dat    = '0;
        csr_byteen = '0;
        for (int i = 0; i < R; i++) begin
            if (lane == LANE_WIDTH'(i)) begin
                csr_dat    = mem_dat[i*CSR_DATA_WIDTH +: CSR_DATA_WIDTH];
                csr_byteen = mem_byteen[i*(CSR_DATA_WIDTH/8) +: CSR_DATA_WIDTH/8];
            end
        end
    end

endmodule

// File: rtl/pzcorebus_membus2csrbus_adapter_request_splitter.sv
// Purpose: splits membus burst commands into single-word csrbus commands tagged with id and last.
// Latency: first csr command valid one cycle after the membus command is accepted.
// Backpressure: csr accept stalls splitting; write beats are consumed only on csr handshakes.
module pzcorebus_membus2csrbus_adapter_request_splitter
    import pzcorebus_membus2csrbus_pkg::*;
#(
    parameter int ADDR_WIDTH     = PKG_ADDR_WIDTH,
    parameter int MEM_DATA_WIDTH = PKG_MEM_DATA_WIDTH,
    parameter int CSR_DATA_WIDTH = PKG_CSR_DATA_WIDTH,
    parameter int LENGTH_WIDTH   = PKG_LENGTH_WIDTH,
    parameter int ID_WIDTH       = PKG_ID_WIDTH
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_mcmd_valid,
    output logic                        o_scmd_accept,
    input  logic [1:0]                  i_mcmd,
    input  logic [ID_WIDTH-1:0]         i_mid,
    input  logic [ADDR_WIDTH-1:0]       i_maddr,
    input  logic [LENGTH_WIDTH-1:0]     i_mlength,
    input  logic                        i_mdata_valid,
    output logic                        o_sdata_accept,
    input  logic [MEM_DATA_WIDTH-1:0]   i_mdata,
    input  logic [MEM_DATA_WIDTH/8-1:0] i_mdata_byteen,
    input  logic                        i_mdata_last,
    output logic                        o_csr_mcmd_valid,
    input  logic                        i_csr_scmd_accept,
    output logic [1:0]                  o_csr_mcmd,
    output logic [ADDR_WIDTH-1:0]       o_csr_maddr,
    output logic [CSR_DATA_WIDTH-1:0]   o_csr_mdata,
    output logic [CSR_DATA_WIDTH/8-1:0] o_csr_mdata_byteen,
    output logic [ID_WIDTH-1:0]         o_csr_mid,
    output logic                        o_csr_last,
    output logic                        o_protocol_error
);
    localparam int    R         = MEM_DATA_WIDTH / CSR_DATA_WIDTH;
    localparam int    BYTE_OFF  = $clog2(CSR_DATA_WIDTH / 8);
    localparam lane_t LAST_LANE = lane_t'(R - 1);

    split_state_e state_q, state_d;
    split_ctx_t   ctx_q, ctx_d;
    logic         error_q, error_d;
    logic         busy, csr_vld, csr_hs, last_word, beat_take;
    logic [CSR_DATA_WIDTH-1:0]   lane_dat;
    logic [CSR_DATA_WIDTH/8-1:0] lane_byteen;

    pzcorebus_membus2csrbus_adapter_lane_select #(
        .MEM_DATA_WIDTH (MEM_DATA_WIDTH),
        .CSR_DATA_WIDTH (CSR_DATA_WIDTH),
        .LANE_WIDTH     (PKG_LANE_WIDTH)
    ) u_lane_select (
        .lane       (ctx_q.lane),
        .mem_dat    (i_mdata),
        .mem_byteen (i_mdata_byteen),
        .csr_dat    (lane_dat),
        .csr_byteen (lane_byteen)
    );

    always_comb begin
        busy      = (state_q != IDLE);
        last_word = busy && (ctx_q.remaining == remaining_t'(1));
        csr_vld   = !i_rst && ((state_q == READ_SPLIT) ||
                               ((state_q == WRITE_SPLIT) && i_mdata_valid));
        csr_hs    = csr_vld && i_csr_scmd_accept;
        // A beat retires after its top lane, or early when the burst ends mid-beat.
        beat_take = csr_hs && (state_q == WRITE_SPLIT) &&
                    ((ctx_q.lane == LAST_LANE) || last_word);

        state_d = state_q;
        ctx_d   = ctx_q;
        error_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_mcmd_valid && !i_rst) begin
                    ctx_d.cmd       = cmd_type_e'(i_mcmd);
                    ctx_d.id        = i_mid;
                    ctx_d.addr      = i_maddr;
                    ctx_d.remaining = burst_words(i_mlength);
                    ctx_d.lane      = (R > 1) ? i_maddr[BYTE_OFF +: PKG_LANE_WIDTH] : '0;
                    case (cmd_type_e'(i_mcmd))
                        CMD_READ:                        state_d = READ_SPLIT;
                        CMD_WRITE, CMD_WRITE_NON_POSTED: state_d = WRITE_SPLIT;
                        default:                         error_d = 1'b1;
                    endcase
                end
            end
            default: begin
                if (csr_hs) begin
                    ctx_d.addr      = ctx_q.addr + ADDR_WIDTH'(CSR_DATA_WIDTH / 8);
                    ctx_d.remaining = ctx_q.remaining - remaining_t'(1);
                    ctx_d.lane      = (ctx_q.lane == LAST_LANE) ? '0 : ctx_q.lane + lane_t'(1);
                    if (last_word) begin
                        state_d = IDLE;
                    end
                end
            end
        endcase

        // Beat framing disagrees with the command length; keep splitting regardless.
        if (beat_take && (i_mdata_last != last_word)) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            ctx_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctx_q   <= ctx_d;
            error_q <= error_d;
        end
    end

    assign o_scmd_accept      = !i_rst && (state_q == IDLE);
    assign o_sdata_accept     = beat_take;
    assign o_csr_mcmd_valid   = csr_vld;
    assign o_csr_mcmd         = busy ? ctx_q.cmd  : CMD_READ;
    assign o_csr_maddr        = busy ? ctx_q.addr : '0;
    assign o_csr_mid          = busy ? ctx_q.id   : '0;
    assign o_csr_last         = last_word;
    assign o_csr_mdata        = (state_q == WRITE_SPLIT) ? lane_dat    : '0;
    assign o_csr_mdata_byteen = (state_q == WRITE_SPLIT) ? lane_byteen : '0;
    assign o_protocol_error   = error_q;

endmodule

// File: tb/tb_pzcorebus_membus2csrbus_adapter_request_splitter.sv
// Directed bench for the request splitter: reads, writes, wrap, stalls, framing errors, reset.
module tb_pzcorebus_membus2csrbus_adapter_request_splitter;

    logic        clk = 1'b0;
    logic        rst;
    logic        mcmd_vld;
    logic        scmd_acc;
    logic [1:0]  mcmd;
    logic [7:0]  mid;
    logic [31:0] maddr;
    logic [7:0]  mlength;
    logic        mdata_vld;
    logic        sdata_acc;
    logic [63:0] mdata;
    logic [7:0]  mdata_be;
    logic        mdata_last;
    logic        csr_vld;
    logic        csr_acc;
    logic [1:0]  csr_cmd;
    logic [31:0] csr_addr;
    logic [31:0] csr_dat;
    logic [3:0]  csr_be;
    logic [7:0]  csr_id;
    logic        csr_last;
    logic        proto_err;

    int checks   = 0;
    int failures = 0;
    int err_pulses = 0;
    int err_base;
    bit toggle_acc = 1'b0;
    bit beat_taken = 1'b0;
    int beat_idx   = 0;
    logic [63:0] beat_dat[$];
    logic [7:0]  beat_be[$];
    logic        beat_last[$];

    always #5 clk = ~clk;

    always @(negedge clk) if (proto_err === 1'b1) err_pulses++;

    pzcorebus_membus2csrbus_adapter_request_splitter dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_mcmd_valid       (mcmd_vld),
        .o_scmd_accept      (scmd_acc),
        .i_mcmd             (mcmd),
        .i_mid              (mid),
        .i_maddr            (maddr),
        .i_mlength          (mlength),
        .i_mdata_valid      (mdata_vld),
        .o_sdata_accept     (sdata_acc),
        .i_mdata            (mdata),
        .i_mdata_byteen     (mdata_be),
        .i_mdata_last       (mdata_last),
        .o_csr_mcmd_valid   (csr_vld),
        .i_csr_scmd_accept  (csr_acc),
        .o_csr_mcmd         (csr_cmd),
        .o_csr_maddr        (csr_addr),
        .o_csr_mdata        (csr_dat),
        .o_csr_mdata_byteen (csr_be),
        .o_csr_mid          (csr_id),
        .o_csr_last         (csr_last),
        .o_protocol_error   (proto_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_beat();
        if (beat_idx < beat_dat.size()) begin
            mdata_vld  = 1'b1;
            mdata      = beat_dat[beat_idx];
            mdata_be   = beat_be[beat_idx];
            mdata_last = beat_last[beat_idx];
        end else begin
            mdata_vld  = 1'b0;
            mdata      = '0;
            mdata_be   = '0;
            mdata_last = 1'b0;
        end
    endtask

    task automatic load_beats_clear();
        beat_dat.delete();
        beat_be.delete();
        beat_last.delete();
        beat_idx = 0;
    endtask

    task automatic push_beat(input logic [63:0] d, input logic [7:0] be, input logic last);
        beat_dat.push_back(d);
        beat_be.push_back(be);
        beat_last.push_back(last);
    endtask

    // Called at a settled point; moves to the next negedge and advances stimulus.
    task automatic tick();
        beat_taken = sdata_acc;
        @(negedge clk);
        if (beat_taken) begin
            beat_idx++;
            drive_beat();
        end
        if (toggle_acc) csr_acc = !csr_acc;
    endtask

    task automatic send_cmd(input string tag, input logic [1:0] c, input logic [7:0] id,
                            input logic [31:0] a, input logic [7:0] len);
        int n;
        mcmd_vld = 1'b1;
        mcmd     = c;
        mid      = id;
        maddr    = a;
        mlength  = len;
        #1;
        n = 0;
        while (!scmd_acc && n < 20) begin
            tick();
            #1;
            n++;
        end
        check_eq({tag, "_cmd_accept"}, scmd_acc, 1);
        tick();
        mcmd_vld = 1'b0;
    endtask

    task automatic collect_sub(input string tag, input logic [31:0] ea, input logic el,
                               input logic [31:0] ed, input logic [3:0] eb, input logic [1:0] ec,
                               input logic [7:0] eid, input logic esacc);
        int n;
        #1;
        n = 0;
        while (!(csr_vld && csr_acc) && n < 40) begin
            if (csr_vld) begin
                check_eq({tag, "_stall_addr"}, csr_addr, ea);
                check_eq({tag, "_stall_data"}, csr_dat, ed);
                check_eq({tag, "_stall_last"}, csr_last, el);
            end
            tick();
            #1;
            n++;
        end
        check_eq({tag, "_handshake"}, csr_vld && csr_acc, 1);
        check_eq({tag, "_addr"}, csr_addr, ea);
        check_eq({tag, "_last"}, csr_last, el);
        check_eq({tag, "_data"}, csr_dat, ed);
        check_eq({tag, "_byteen"}, csr_be, eb);
        check_eq({tag, "_cmd"}, csr_cmd, ec);
        check_eq({tag, "_id"}, csr_id, eid);
        check_eq({tag, "_sdata_accept"}, sdata_acc, esacc);
        tick();
    endtask

    task automatic idle_check(input string tag);
        #1;
        check_eq({tag, "_idle_valid"}, csr_vld, 0);
        check_eq({tag, "_idle_accept"}, scmd_acc, 1);
        tick();
    endtask

    initial begin
        rst = 1'b1; mcmd_vld = 1'b0; mcmd = '0; mid = '0; maddr = '0; mlength = '0;
        mdata_vld = 1'b0; mdata = '0; mdata_be = '0; mdata_last = 1'b0; csr_acc = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_hold_scmd_accept", scmd_acc, 0);
        check_eq("rst_hold_csr_valid", csr_vld, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_scmd_accept", scmd_acc, 1);
        check_eq("rst_csr_valid", csr_vld, 0);
        check_eq("rst_proto_err", proto_err, 0);
        check_eq("rst_sdata_accept", sdata_acc, 0);
        check_eq("rst_addr", csr_addr, 0);
        check_eq("rst_last", csr_last, 0);
        tick();

        // Read burst of three words.
        send_cmd("rd3", 2'd0, 8'h5A, 32'h100, 8'd3);
        collect_sub("rd3_w0", 32'h100, 1'b0, 32'h0, 4'h0, 2'd0, 8'h5A, 1'b0);
        collect_sub("rd3_w1", 32'h104, 1'b0, 32'h0, 4'h0, 2'd0, 8'h5A, 1'b0);
        collect_sub("rd3_w2", 32'h108, 1'b1, 32'h0, 4'h0, 2'd0, 8'h5A, 1'b0);
        idle_check("rd3");

        // Posted write starting in the upper lane.
        #1 err_base = err_pulses;
        load_beats_clear();
        push_beat(64'hA0A1A2A3_B0B1B2B3, 8'hA5, 1'b0);
        push_beat(64'hC0C1C2C3_D0D1D2D3, 8'h3C, 1'b1);
        drive_beat();
        @(negedge clk);
        send_cmd("wr3", 2'd1, 8'h21, 32'h204, 8'd3);
        collect_sub("wr3_w0", 32'h204, 1'b0, 32'hA0A1A2A3, 4'hA, 2'd1, 8'h21, 1'b1);
        collect_sub("wr3_w1", 32'h208, 1'b0, 32'hD0D1D2D3, 4'hC, 2'd1, 8'h21, 1'b0);
        collect_sub("wr3_w2", 32'h20C, 1'b1, 32'hC0C1C2C3, 4'h3, 2'd1, 8'h21, 1'b1);
        check_eq("wr3_beats_used", beat_idx, 2);
        check_eq("wr3_no_error", err_pulses - err_base, 0);
        idle_check("wr3");

        // Non-posted write, length 0 means 256 words, csr accept toggling.
        #1 err_base = err_pulses;
        load_beats_clear();
        for (int k = 0; k < 128; k++)
            push_beat({32'hE000_0000 + 32'(2*k+1), 32'hE000_0000 + 32'(2*k)}, 8'hFF, k == 127);
        drive_beat();
        @(negedge clk);
        send_cmd("np256", 2'd2, 8'h77, 32'h1000, 8'd0);
        toggle_acc = 1'b1;
        for (int w = 0; w < 256; w++)
            collect_sub($sformatf("np256_w%0d", w), 32'h1000 + 32'(4*w), w == 255,
                        32'hE000_0000 + 32'(w), 4'hF, 2'd2, 8'h77, w[0]);
        toggle_acc = 1'b0;
        csr_acc = 1'b1;
        check_eq("np256_beats_used", beat_idx, 128);
        check_eq("np256_no_error", err_pulses - err_base, 0);
        idle_check("np256");

        // Address wrap at the top of the space.
        send_cmd("wrap", 2'd0, 8'h33, 32'hFFFF_FFFC, 8'd2);
        collect_sub("wrap_w0", 32'hFFFF_FFFC, 1'b0, 32'h0, 4'h0, 2'd0, 8'h33, 1'b0);
        collect_sub("wrap_w1", 32'h0000_0000, 1'b1, 32'h0, 4'h0, 2'd0, 8'h33, 1'b0);
        idle_check("wrap");

        // Reserved command is dropped with a single error pulse.
        #1 err_base = err_pulses;
        @(negedge clk);
        send_cmd("rsvd", 2'd3, 8'h99, 32'h800, 8'd4);
        #1;
        check_eq("rsvd_error_pulse", proto_err, 1);
        check_eq("rsvd_no_valid", csr_vld, 0);
        check_eq("rsvd_accept", scmd_acc, 1);
        tick();
        #1;
        check_eq("rsvd_error_clear", proto_err, 0);
        check_eq("rsvd_pulse_count", err_pulses - err_base, 1);
        tick();

        // Early last on the first beat of a four-word write.
        #1 err_base = err_pulses;
        load_beats_clear();
        push_beat(64'h0000_0002_0000_0001, 8'hFF, 1'b1);
        push_beat(64'h0000_0004_0000_0003, 8'hFF, 1'b1);
        drive_beat();
        @(negedge clk);
        send_cmd("early", 2'd1, 8'h44, 32'h300, 8'd4);
        collect_sub("early_w0", 32'h300, 1'b0, 32'h1, 4'hF, 2'd1, 8'h44, 1'b0);
        collect_sub("early_w1", 32'h304, 1'b0, 32'h2, 4'hF, 2'd1, 8'h44, 1'b1);
        collect_sub("early_w2", 32'h308, 1'b0, 32'h3, 4'hF, 2'd1, 8'h44, 1'b0);
        collect_sub("early_w3", 32'h30C, 1'b1, 32'h4, 4'hF, 2'd1, 8'h44, 1'b1);
        idle_check("early");
        check_eq("early_pulse_count", err_pulses - err_base, 1);

        // Reset after two of five words, then a clean burst.
        send_cmd("abort", 2'd0, 8'h66, 32'h400, 8'd5);
        collect_sub("abort_w0", 32'h400, 1'b0, 32'h0, 4'h0, 2'd0, 8'h66, 1'b0);
        collect_sub("abort_w1", 32'h404, 1'b0, 32'h0, 4'h0, 2'd0, 8'h66, 1'b0);
        rst = 1'b1;
        #1;
        check_eq("abort_rst_valid", csr_vld, 0);
        check_eq("abort_rst_accept", scmd_acc, 0);
        tick();
        rst = 1'b0;
        #1;
        check_eq("abort_after_valid", csr_vld, 0);
        check_eq("abort_after_accept", scmd_acc, 1);
        check_eq("abort_after_addr", csr_addr, 0);
        tick();
        send_cmd("resume", 2'd0, 8'h67, 32'h500, 8'd2);
        collect_sub("resume_w0", 32'h500, 1'b0, 32'h0, 4'h0, 2'd0, 8'h67, 1'b0);
        collect_sub("resume_w1", 32'h504, 1'b1, 32'h0, 4'h0, 2'd0, 8'h67, 1'b0);
        idle_check("resume");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pzcorebus_membus2csrbus_adapter_request_splitter.md
Name: pzcorebus_membus2csrbus_adapter_request_splitter

Overview:
- Request-side stage of the membus-to-csrbus adapter. Sits between the membus slave port and the csrbus response-tracking buffer.
- Converts each membus burst command into a sequence of single-word csrbus commands:
  - reads: one csr read per word;
  - writes: one csr write per word, with the data word and byte enables carried inline in the command.
- Tags every issued sub-command with its parent id and a last-of-burst flag, so downstream stages can rebuild burst responses.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- MEM_DATA_WIDTH, 64, membus write-data beat width.
- CSR_DATA_WIDTH, 32, csrbus data width. MEM_DATA_WIDTH must be a multiple of it; R = MEM_DATA_WIDTH/CSR_DATA_WIDTH.
- LENGTH_WIDTH, 8, burst length width, in csr words. Value 0 encodes 2**LENGTH_WIDTH words.
- ID_WIDTH, 8, membus/csrbus id width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_mcmd_valid  in  1  membus command valid.
- o_scmd_accept  out  1  membus command accept.
- i_mcmd  in  2  command type: READ=0, WRITE=1, WRITE_NON_POSTED=2, 3 reserved.
- i_mid  in  ID_WIDTH  membus command id.
- i_maddr  in  ADDR_WIDTH  start byte address; csr-word aligned.
- i_mlength  in  LENGTH_WIDTH  burst length in csr words.
- i_mdata_valid  in  1  write-data beat valid.
- o_sdata_accept  out  1  write-data beat accept.
- i_mdata  in  MEM_DATA_WIDTH  write-data beat.
- i_mdata_byteen  in  MEM_DATA_WIDTH/8  beat byte enables.
- i_mdata_last  in  1  final beat of the burst.
- o_csr_mcmd_valid  out  1  csrbus command valid.
- i_csr_scmd_accept  in  1  csrbus command accept.
- o_csr_mcmd  out  2  sub-command type (same encoding as i_mcmd).
- o_csr_maddr  out  ADDR_WIDTH  sub-command byte address.
- o_csr_mdata  out  CSR_DATA_WIDTH  write word; 0 for reads.
- o_csr_mdata_byteen  out  CSR_DATA_WIDTH/8  write byte enables; 0 for reads.
- o_csr_mid  out  ID_WIDTH  parent membus id.
- o_csr_last  out  1  sub-command is the final word of its burst.
- o_protocol_error  out  1  one-cycle pulse on a burst/data mismatch.

Behaviour:
- Reset (synchronous on i_rst): state=IDLE; all outputs 0; counters and lane cleared. Reset mid-burst abandons the burst with no flush.
- States and transitions:
  - IDLE: o_scmd_accept=1, no csr output. On an accepted command, latch type, id, address, remaining = (i_mlength==0 ? 2**LENGTH_WIDTH : i_mlength), lane = maddr[csr-word index bits] mod R.
  - IDLE -> READ_SPLIT when type is READ. IDLE -> WRITE_SPLIT when type is WRITE or WRITE_NON_POSTED.
  - IDLE -> IDLE when type is 3: command is dropped and o_protocol_error pulses.
  - READ_SPLIT: o_csr_mcmd_valid=1 continuously.
  - WRITE_SPLIT: o_csr_mcmd_valid = i_mdata_valid. The word is lane `lane` of i_mdata, with the matching byteen slice.
- Per sub-command handshake (valid && i_csr_scmd_accept):
  - address += CSR_DATA_WIDTH/8, wrapping modulo 2**ADDR_WIDTH;
  - remaining -= 1;
  - lane = (lane==R-1) ? 0 : lane+1.
- o_csr_last = (remaining==1). The handshake with o_csr_last=1 returns the block to IDLE.
- Write data beats:
  - o_sdata_accept = csr handshake in WRITE_SPLIT && (lane==R-1 || remaining==1). One beat is consumed per R words, or early on the final word.
  - If i_mdata_last=1 on a consumed beat with remaining>1, or i_mdata_last=0 on the final word's beat: o_protocol_error pulses for one cycle and splitting continues to the command length.
- All csr outputs are driven from registered state plus the current beat. Output values stay stable while valid is high and accept is low, provided the membus beat is stable.
- No new command is accepted until the current burst completes. Latency from membus accept to first csr valid is 1 cycle.
- Throughput: one sub-command per cycle when accept is held high.
- Zero-byteen words are still issued; no suppression.

Decomposition:
- pzcorebus_membus2csrbus_pkg:
  - command-type enum;
  - state enum (IDLE, READ_SPLIT, WRITE_SPLIT);
  - the split-context struct {type, id, addr, remaining, lane}.
- One sub-module, pzcorebus_membus2csrbus_adapter_lane_select: a combinational R:1 mux of word and byteen indexed by lane. Kept separate for reuse on the response packer.

Test Plan:
- READ, addr 0x100, length 3, accept always 1 -> three reads at 0x100/0x104/0x108 on consecutive cycles; last=0,0,1; id echoed; back in IDLE on the next cycle.
- WRITE, addr 0x204, length 3, beats D0/D1 (R=2) -> words D0[63:32]@0x204, D1[31:0]@0x208, D1[63:32]@0x20C; sdata_accept on the 1st and 3rd handshakes.
- WRITE_NON_POSTED, length 0 (256 words), i_csr_scmd_accept toggling every cycle -> 256 sub-commands in order; outputs stable while stalled; single last on word 256.
- READ at addr 0xFFFFFFFC, length 2 -> addresses 0xFFFFFFFC then 0x00000000.
- WRITE length 4 with i_mdata_last=1 on the first beat -> o_protocol_error pulses once; all 4 words still issued.
- i_rst asserted mid-burst after 2 of 5 words -> next cycle valid=0, o_scmd_accept=1; the following command splits cleanly from its own address.
